uart_tx: RTL

- Serial transmitter for the RS-232 link. It is the stage that drives the board TX pin and sits beside the rs232rx receiver inside top.
- Accepts one byte per valid/ready handshake and shifts it out as 8N1 (8 data bits, no parity, 1 stop bit by default), LSB first, at a fixed baud rate.
- Typical use: echo or report bytes back to the host. Upstream is a byte source, e.g. the receiver's data/ready or a future FIFO.

---
 rtl/uart_tx.sv | 130 +++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 (or 8E1 with UART_TX_PARITY_EN) serial transmitter with valid/ready byte input
module uart_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] baud;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          stop_cnt;
  logic          wrap;
`ifdef UART_TX_PARITY_EN
  logic          par;
`endif

  // A bit period ends when the baud counter is about to wrap.
  assign wrap = (baud == BAUD_LAST);

  // Baud counter: parked at zero while idle, free-running 0..N-1 during a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      baud <= '0;
    end else if (state == S_IDLE) begin
      baud <= '0;
    end else if (wrap) begin
      baud <= '0;
    end else begin
      baud <= baud + CW'(1);
    end
  end

  // Frame sequencer: tx and ready are registered here so no input reaches tx combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tx       <= 1'b1;
      ready    <= 1'b1;
      bit_cnt  <= 3'd0;
      shreg    <= 8'd0;
      stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (valid && ready) begin
            shreg    <= data;
            ready    <= 1'b0;
            tx       <= 1'b0;
            bit_cnt  <= 3'd0;
            stop_cnt <= 1'b0;
            state    <= S_START;
`ifdef UART_TX_PARITY_EN
            par      <= ^data;
`endif
          end
        end
        S_START: begin
          if (wrap) begin
            tx    <= shreg[0];
            shreg <= {1'b0, shreg[7:1]};
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (wrap) begin
            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx    <= par;
              state <= S_PARITY;
`else
              tx    <= 1'b1;
              state <= S_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (wrap) begin
            tx    <= 1'b1;
            state <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (wrap) begin
            if (stop_cnt == STOP_LAST) begin
              ready <= 1'b1;
              state <= S_IDLE;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
